// File: rtl/ecore_lsu_if.sv
`default_nettype none
// ============================================================================
// ecore_lsu_if : execute-stage request/response and data-RAM port bundle
// Revision     : 1.0
// ============================================================================
interface ecore_lsu_if #(
    parameter int ADDR_BITS = 30
);
    logic                 i_req_valid;
    logic                 o_req_ready;
    logic                 i_req_store;
    logic [2:0]           i_req_funct3;
    logic [31:0]          i_req_addr;
    logic [31:0]          i_req_wdata;
    logic                 o_resp_valid;
    logic [31:0]          o_resp_rdata;
    logic                 o_resp_fault;
    logic [ADDR_BITS-1:0] o_ram_addr;
    logic                 o_ram_we;
    logic [31:0]          o_ram_wdata;
    logic [31:0]          i_ram_rdata;

    modport slave (
        input  i_req_valid, i_req_store, i_req_funct3, i_req_addr, i_req_wdata, i_ram_rdata,
        output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_fault,
               o_ram_addr, o_ram_we, o_ram_wdata
    );

    modport master (
        output i_req_valid, i_req_store, i_req_funct3, i_req_addr, i_req_wdata, i_ram_rdata,
        input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_fault,
               o_ram_addr, o_ram_we, o_ram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/ecore_lsu.sv
`default_nettype none
// ============================================================================
// ecore_lsu : byte-addressed load/store unit over a word-wide RAM (RMW stores)
// Revision  : 1.0
// ============================================================================
module ecore_lsu #(
    parameter int ADDR_BITS = 30
) (
    input  wire logic    i_clk,
    input  wire logic    i_rst,
    ecore_lsu_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    state_t      r_state;
    state_t      w_next;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wbuf;
    logic [31:0] r_result;
    logic        r_fault;

    logic        w_accept;
    logic        w_req_fault;
    logic        w_ready;
    logic        w_resp_valid;
    logic        w_we;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_accept = (r_state == ST_IDLE) && bus.i_req_valid;

    always_comb begin
        w_req_fault = 1'b0;
        if (bus.i_req_store) begin
            if (bus.i_req_funct3[2] || (bus.i_req_funct3[1:0] == 2'b11)) begin
                w_req_fault = 1'b1;
            end
        end else begin
            if ((bus.i_req_funct3 == 3'b011) || (bus.i_req_funct3[2:1] == 2'b11)) begin
                w_req_fault = 1'b1;
            end
        end
        if ((bus.i_req_funct3[1:0] == 2'b01) && bus.i_req_addr[0]) begin
            w_req_fault = 1'b1;
        end
        if ((bus.i_req_funct3[1:0] == 2'b10) && (bus.i_req_addr[1:0] != 2'b00)) begin
            w_req_fault = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_ready      = 1'b0;
        w_resp_valid = 1'b0;
        w_we         = 1'b0;
        w_wdata      = 32'd0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (bus.i_req_valid) begin
                    if (w_req_fault) begin
                        w_next = ST_RESP;
                    end else if (bus.i_req_store && (bus.i_req_funct3 == c_F3_W)) begin
                        w_next = ST_WRITE;
                    end else begin
                        w_next = ST_READ;
                    end
                end
            end
            ST_READ:  w_next = ST_WAIT;
            ST_WAIT:  w_next = r_store ? ST_WRITE : ST_RESP;
            ST_WRITE: begin
                w_we    = 1'b1;
                w_wdata = r_wbuf;
                w_next  = ST_RESP;
            end
            ST_RESP: begin
                w_resp_valid = 1'b1;
                w_next       = ST_IDLE;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    // Lane selection for loads, lane merge for sub-word stores.
    assign w_shift = bus.i_ram_rdata >> {r_addr[1:0], 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = r_addr[1] ? bus.i_ram_rdata[31:16] : bus.i_ram_rdata[15:0];

    always_comb begin
        case (r_funct3)
            c_F3_B:  w_load = {{24{w_byte[7]}}, w_byte};
            c_F3_H:  w_load = {{16{w_half[15]}}, w_half};
            c_F3_BU: w_load = {24'd0, w_byte};
            c_F3_HU: w_load = {16'd0, w_half};
            default: w_load = bus.i_ram_rdata;
        endcase
    end

    always_comb begin
        w_merged = bus.i_ram_rdata;
        if (r_funct3 == c_F3_H) begin
            if (r_addr[1]) begin
                w_merged[31:16] = r_wbuf[15:0];
            end else begin
                w_merged[15:0] = r_wbuf[15:0];
            end
        end else begin
            case (r_addr[1:0])
                2'd0:    w_merged[7:0]   = r_wbuf[7:0];
                2'd1:    w_merged[15:8]  = r_wbuf[7:0];
                2'd2:    w_merged[23:16] = r_wbuf[7:0];
                default: w_merged[31:24] = r_wbuf[7:0];
            endcase
        end
    end

    // r_wbuf holds raw store data until a sub-word store merges it into the read word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_store  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wbuf   <= 32'd0;
            r_result <= 32'd0;
            r_fault  <= 1'b0;
        end else if (w_accept) begin
            r_store  <= bus.i_req_store;
            r_funct3 <= bus.i_req_funct3;
            r_addr   <= bus.i_req_addr;
            r_wbuf   <= bus.i_req_wdata;
            r_result <= 32'd0;
            r_fault  <= w_req_fault;
        end else if (r_state == ST_WAIT) begin
            if (r_store) begin
                r_wbuf <= w_merged;
            end else begin
                r_result <= w_load;
            end
        end
    end

    assign bus.o_req_ready  = w_ready & ~i_rst;
    assign bus.o_resp_valid = w_resp_valid & ~i_rst;
    assign bus.o_resp_rdata = (w_resp_valid && !i_rst) ? r_result : 32'd0;
    assign bus.o_resp_fault = w_resp_valid & r_fault & ~i_rst;
    assign bus.o_ram_addr   = i_rst ? {ADDR_BITS{1'b0}} : r_addr[ADDR_BITS+1:2];
    assign bus.o_ram_we     = w_we & ~i_rst;
    assign bus.o_ram_wdata  = i_rst ? 32'd0 : w_wdata;
endmodule
`default_nettype wire

// File: tb/tb_ecore_lsu.sv
`default_nettype none
// ============================================================================
// tb_ecore_lsu : randomized + directed bench against a byte-level memory model
// Revision     : 1.0
// ============================================================================
module tb_ecore_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ecore_lsu_if #(.ADDR_BITS(30)) bus ();
    ecore_lsu #(.ADDR_BITS(30)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] ram [0:255];
    logic [7:0]  ref_mem [0:1023];
    logic        pre_we  = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    logic [31:0] pre_dat = 32'd0;

    always @(posedge clk) begin
        if (pre_we) ram[pre_idx] <= pre_dat;
        else if (bus.o_ram_we) ram[bus.o_ram_addr[7:0]] <= bus.o_ram_wdata;
        bus.i_ram_rdata <= ram[bus.o_ram_addr[7:0]];
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] b;
        b = a & 32'h3FC;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic preload(input int idx, input logic [31:0] w);
        pre_we = 1'b1; pre_idx = idx[7:0]; pre_dat = w;
        for (int i = 0; i < 4; i++) ref_mem[idx*4+i] = w[8*i +: 8];
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Little-endian byte memory: expected outcome of one request; updates ref_mem on stores.
    task automatic model_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output int lat, output logic [31:0] rd,
                             output logic flt, output int nwr, output int wcyc,
                             output logic [31:0] wword);
        int nb;
        logic legal;
        nb = 1 << f3[1:0];
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        flt = !(legal && ((a % nb) == 0));
        rd = 32'd0; nwr = 0; wcyc = -1; wword = 32'd0;
        if (flt) begin
            lat = 1;
        end else if (st) begin
            for (int i = 0; i < nb; i++) ref_mem[a+i] = wd[8*i +: 8];
            wword = ref_word(a);
            nwr = 1;
            lat  = (f3 == 3'd2) ? 2 : 4;
            wcyc = (f3 == 3'd2) ? 1 : 3;
        end else begin
            for (int i = 0; i < nb; i++) rd = rd | (32'(ref_mem[a+i]) << (8*i));
            if (!f3[2] && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8*nb));
            lat = 3;
        end
    endtask

    // Drives one request from an IDLE negedge and records what the DUT did.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic flt, output int nwr, output int wcyc,
                          output logic [29:0] wadr, output logic [31:0] wdat,
                          output int bad, output logic rdy0, output logic rdy1);
        lat = -1; rd = 32'd0; flt = 1'b0; nwr = 0; wcyc = -1; wadr = 30'd0; wdat = 32'd0; bad = 0;
        rdy0 = bus.o_req_ready;
        bus.i_req_valid = 1'b1; bus.i_req_store = st; bus.i_req_funct3 = f3;
        bus.i_req_addr = a; bus.i_req_wdata = wd;
        @(posedge clk);
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.i_req_valid = 1'b0; bus.i_req_addr = $urandom; bus.i_req_wdata = $urandom;
                bus.i_req_funct3 = 3'($urandom); bus.i_req_store = 1'($urandom);
            end
            if (bus.o_ram_we) begin
                nwr++; wcyc = c; wadr = bus.o_ram_addr; wdat = bus.o_ram_wdata;
            end else if (bus.o_ram_wdata !== 32'd0) begin
                bad++;
            end
            if (bus.o_resp_valid) begin
                lat = c; rd = bus.o_resp_rdata; flt = bus.o_resp_fault;
            end
        end
        @(negedge clk);
        rdy1 = bus.o_req_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 256; i++) preload(i, $urandom);
        n_chk++; if (bus.o_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low got=%b exp=0", bus.o_req_ready); end
        n_chk++; if (bus.o_ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we_low got=%b exp=0", bus.o_ram_we); end
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got=%b exp=1", bus.o_req_ready); end
        n_chk++; if (bus.o_ram_addr !== 30'd0) begin n_fail++; $display("FAIL reset_ram_addr got=%h exp=0", bus.o_ram_addr); end
        n_chk++; if (bus.o_resp_rdata !== 32'd0 || bus.o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp got=%b/%h exp=0/0", bus.o_resp_valid, bus.o_resp_rdata); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] adrs [5] = '{32'h13, 32'h12, 32'h12, 32'h10, 32'h10};
        logic [31:0] exps [5] = '{32'hFFFFFF88, 32'h00000099, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
        int lat, nwr, wcyc, bad; logic [31:0] rd, wdat; logic [29:0] wadr; logic flt, r0, r1;
        preload(4, 32'h8899AABB);
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, f3s[i], adrs[i], 32'h0, lat, rd, flt, nwr, wcyc, wadr, wdat, bad, r0, r1);
            n_chk++; if (rd !== exps[i]) begin n_fail++; $display("FAIL load_data[%0d] got=%h exp=%h", i, rd, exps[i]); end
            n_chk++; if (lat !== 3 || flt !== 1'b0 || nwr !== 0) begin n_fail++; $display("FAIL load_timing[%0d] got lat=%0d flt=%b wr=%0d exp lat=3 flt=0 wr=0", i, lat, flt, nwr); end
        end
    endtask

    task automatic test_stores();
        int lat, nwr, wcyc, bad, el, en, ec; logic [31:0] rd, wdat, er, ew; logic [29:0] wadr; logic flt, r0, r1, ef;
        do_req(1'b1, 3'b000, 32'h11, 32'h12345677, lat, rd, flt, nwr, wcyc, wadr, wdat, bad, r0, r1);
        model_req(1'b1, 3'b000, 32'h11, 32'h12345677, el, er, ef, en, ec, ew);
        n_chk++; if (nwr !== 1 || wcyc !== 3 || wdat !== 32'h889977BB || wadr !== 30'h4) begin n_fail++; $display("FAIL sb_write got n=%0d cyc=%0d addr=%h data=%h exp 1/3/4/889977bb", nwr, wcyc, wadr, wdat); end
        n_chk++; if (lat !== 4 || rd !== 32'd0 || bad !== 0) begin n_fail++; $display("FAIL sb_resp got lat=%0d rd=%h bad=%0d exp 4/0/0", lat, rd, bad); end
        do_req(1'b1, 3'b001, 32'h12, 32'h0000CAFE, lat, rd, flt, nwr, wcyc, wadr, wdat, bad, r0, r1);
        model_req(1'b1, 3'b001, 32'h12, 32'h0000CAFE, el, er, ef, en, ec, ew);
        n_chk++; if (nwr !== 1 || wcyc !== 3 || wdat !== 32'hCAFE77BB || lat !== 4) begin n_fail++; $display("FAIL sh_write got n=%0d cyc=%0d data=%h lat=%0d exp 1/3/cafe77bb/4", nwr, wcyc, wdat, lat); end
        do_req(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, lat, rd, flt, nwr, wcyc, wadr, wdat, bad, r0, r1);
        model_req(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, el, er, ef, en, ec, ew);
        n_chk++; if (nwr !== 1 || wcyc !== 1 || wadr !== 30'h8 || wdat !== 32'hDEADBEEF || lat !== 2) begin n_fail++; $display("FAIL sw got n=%0d cyc=%0d addr=%h data=%h lat=%0d exp 1/1/8/deadbeef/2", nwr, wcyc, wadr, wdat, lat); end
        do_req(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, flt, nwr, wcyc, wadr, wdat, bad, r0, r1);
        n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_readback got=%h exp=deadbeef", rd); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, flt, nwr, wcyc, wadr, wdat, bad, r0, r1);
        n_chk++; if (rd !== 32'hCAFE77BB) begin n_fail++; $display("FAIL rmw_readback got=%h exp=cafe77bb", rd); end
    endtask

    task automatic test_faults();
        logic        sts  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s  [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
        logic [31:0] adrs [4] = '{32'h22, 32'h13, 32'h10, 32'h10};
        int lat, nwr, wcyc, bad; logic [31:0] rd, wdat; logic [29:0] wadr; logic flt, r0, r1;
        for (int i = 0; i < 4; i++) begin
            do_req(sts[i], f3s[i], adrs[i], 32'hFFFF_FFFF, lat, rd, flt, nwr, wcyc, wadr, wdat, bad, r0, r1);
            n_chk++; if (lat !== 1 || flt !== 1'b1 || rd !== 32'd0 || nwr !== 0) begin n_fail++; $display("FAIL fault[%0d] got lat=%0d flt=%b rd=%h wr=%0d exp 1/1/0/0", i, lat, flt, rd, nwr); end
        end
    endtask

    task automatic test_back_to_back();
        int el, en, ec, lat1, lat2, nrdy, nwe; logic [31:0] e1, e2, ew, rd1, rd2; logic ef, rdy4;
        model_req(1'b0, 3'b010, 32'h10, 32'h0, el, e1, ef, en, ec, ew);
        model_req(1'b0, 3'b010, 32'h20, 32'h0, el, e2, ef, en, ec, ew);
        lat1 = -1; lat2 = -1; nrdy = 0; nwe = 0; rdy4 = 1'b0; rd1 = 32'd0; rd2 = 32'd0;
        bus.i_req_valid = 1'b1; bus.i_req_store = 1'b0; bus.i_req_funct3 = 3'b010; bus.i_req_addr = 32'h10;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.o_ram_we) nwe++;
            if (c <= 3) begin
                if (bus.o_req_ready) nrdy++;
                if (bus.o_resp_valid) begin lat1 = c; rd1 = bus.o_resp_rdata; end
                bus.i_req_addr = $urandom_range(0, 255) * 4;
            end
            if (c == 4) begin rdy4 = bus.o_req_ready; bus.i_req_addr = 32'h20; end
            if (c == 5) bus.i_req_valid = 1'b0;
            if (c >= 5 && bus.o_resp_valid && lat2 < 0) begin lat2 = c; rd2 = bus.o_resp_rdata; end
        end
        n_chk++; if (lat1 !== 3 || rd1 !== e1 || nrdy !== 0) begin n_fail++; $display("FAIL busy_first got lat=%0d rd=%h rdy=%0d exp 3/%h/0", lat1, rd1, nrdy, e1); end
        n_chk++; if (rdy4 !== 1'b1 || lat2 !== 7 || rd2 !== e2 || nwe !== 0) begin n_fail++; $display("FAIL busy_second got rdy=%b lat=%0d rd=%h we=%0d exp 1/7/%h/0", rdy4, lat2, rd2, nwe, e2); end
    endtask

    task automatic test_reset_abort();
        int lat, nwr, wcyc, bad, nwe, nresp, nrdy; logic [31:0] rd, wdat, orig; logic [29:0] wadr; logic flt, r0, r1, rdy_after;
        orig = ref_word(32'h14); nwe = 0; nresp = 0; nrdy = 0;
        bus.i_req_valid = 1'b1; bus.i_req_store = 1'b1; bus.i_req_funct3 = 3'b001;
        bus.i_req_addr = 32'h14; bus.i_req_wdata = $urandom;
        @(posedge clk);
        @(negedge clk); bus.i_req_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (bus.o_ram_we) nwe++;
            if (bus.o_resp_valid) nresp++;
            if (bus.o_req_ready) nrdy++;
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        rdy_after = bus.o_req_ready;
        for (int c = 0; c < 3; c++) begin
            if (bus.o_ram_we) nwe++;
            if (bus.o_resp_valid) nresp++;
            if (c < 2) @(negedge clk);
        end
        n_chk++; if (nwe !== 0 || nresp !== 0 || nrdy !== 0) begin n_fail++; $display("FAIL abort_quiet got we=%0d resp=%0d rdy_in_rst=%0d exp 0/0/0", nwe, nresp, nrdy); end
        n_chk++; if (rdy_after !== 1'b1) begin n_fail++; $display("FAIL abort_ready got=%b exp=1", rdy_after); end
        do_req(1'b0, 3'b010, 32'h14, 32'h0, lat, rd, flt, nwr, wcyc, wadr, wdat, bad, r0, r1);
        n_chk++; if (rd !== orig) begin n_fail++; $display("FAIL abort_word got=%h exp=%h", rd, orig); end
    endtask

    task automatic test_random();
        int lat, nwr, wcyc, bad, el, en, ec; logic [31:0] rd, wdat, er, ew, a, wd; logic [29:0] wadr;
        logic flt, r0, r1, ef, st; logic [2:0] f3;
        for (int i = 0; i < 120; i++) begin
            st = 1'($urandom); f3 = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 1023); wd = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                else if (f3[1]) a[1:0] = 2'b00;
            end
            do_req(st, f3, a, wd, lat, rd, flt, nwr, wcyc, wadr, wdat, bad, r0, r1);
            model_req(st, f3, a, wd, el, er, ef, en, ec, ew);
            n_chk++; if (lat !== el || rd !== er || flt !== ef) begin n_fail++; $display("FAIL rand_resp[%0d] st=%b f3=%0d a=%h got lat=%0d rd=%h flt=%b exp %0d/%h/%b", i, st, f3, a, lat, rd, flt, el, er, ef); end
            n_chk++; if (nwr !== en || (en == 1 && (wcyc !== ec || wdat !== ew || wadr !== a[31:2]))) begin n_fail++; $display("FAIL rand_write[%0d] got n=%0d cyc=%0d addr=%h data=%h exp %0d/%0d/%h/%h", i, nwr, wcyc, wadr, wdat, en, ec, a[31:2], ew); end
            n_chk++; if (r0 !== 1'b1 || r1 !== 1'b1 || bad !== 0) begin n_fail++; $display("FAIL rand_ready[%0d] got rdy0=%b rdy1=%b bad_wdata=%0d exp 1/1/0", i, r0, r1, bad); end
        end
    endtask

    initial begin
        bus.i_req_valid = 1'b0; bus.i_req_store = 1'b0; bus.i_req_funct3 = 3'd0;
        bus.i_req_addr = 32'd0; bus.i_req_wdata = 32'd0;
        @(negedge clk);
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
